// File: rtl/insn_encoder_if.sv
// Descriptor-in / instruction-word-out bus of insn_encoder.
// The master drives descriptors and accepts words; the encoder is the slave.
interface insn_encoder_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [3:0]        cls_i;
  logic [3:0]        alusel_i;
  logic [2:0]        funct3_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [DWIDTH-1:0] imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DWIDTH-1:0] insn_o;
  logic [AWIDTH-1:0] addr_o;

  modport slave (
    input  in_valid_i, cls_i, alusel_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, insn_o, addr_o
  );

  modport master (
    output in_valid_i, cls_i, alusel_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, insn_o, addr_o
  );
endinterface

// File: rtl/insn_encoder.sv
// Encodes operation descriptors into RV32I words and streams them with an auto-incrementing address.
// ALU select codes: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND (10-15 illegal).
module insn_encoder #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned ECNTW  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  insn_encoder_if.slave     bus,
  input  logic              base_load_i,
  input  logic [AWIDTH-1:0] base_addr_i,
  output logic              err_o,
  output logic [ECNTW-1:0]  err_cnt_o
);
  localparam logic [3:0] CLS_R = 4'd0, CLS_I = 4'd1, CLS_LOAD = 4'd2, CLS_STORE = 4'd3,
                         CLS_BRANCH = 4'd4, CLS_LUI = 4'd5, CLS_AUIPC = 4'd6, CLS_JAL = 4'd7,
                         CLS_JALR = 4'd8;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] insn_q, insn_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ECNTW-1:0]  err_cnt_q, err_cnt_d;

  logic [2:0]        alu_f3_c;
  logic              alu_ok_c, alu_alt_c, alu_shift_c;
  logic              fits12_c, fits13_c, fits21_c, shamt_ok_c;
  logic [31:0]       insn_c;
  logic              legal_c, ready_c, accept_c;
  logic [AWIDTH-1:0] cur_addr_c;

  logic [DWIDTH-1:0] imm;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        f3;
  assign imm = bus.imm_i;
  assign rd  = bus.rd_i;
  assign rs1 = bus.rs1_i;
  assign rs2 = bus.rs2_i;
  assign f3  = bus.funct3_i;

  // Immediate must sign-extend from its field width
  assign fits12_c   = (imm[DWIDTH-1:11] == {(DWIDTH-11){imm[11]}});
  assign fits13_c   = (imm[DWIDTH-1:12] == {(DWIDTH-12){imm[12]}});
  assign fits21_c   = (imm[DWIDTH-1:20] == {(DWIDTH-20){imm[20]}});
  assign shamt_ok_c = (imm[DWIDTH-1:5] == '0);

  // ALU select to funct3 / funct7 bit 30
  always_comb begin
    alu_f3_c    = 3'b000;
    alu_ok_c    = 1'b1;
    alu_alt_c   = 1'b0;
    alu_shift_c = 1'b0;
    case (bus.alusel_i)
      ALU_ADD:  alu_f3_c = 3'b000;
      ALU_SUB:  alu_alt_c = 1'b1;
      ALU_SLL:  begin alu_f3_c = 3'b001; alu_shift_c = 1'b1; end
      ALU_SLT:  alu_f3_c = 3'b010;
      ALU_SLTU: alu_f3_c = 3'b011;
      ALU_XOR:  alu_f3_c = 3'b100;
      ALU_SRL:  begin alu_f3_c = 3'b101; alu_shift_c = 1'b1; end
      ALU_SRA:  begin alu_f3_c = 3'b101; alu_shift_c = 1'b1; alu_alt_c = 1'b1; end
      ALU_OR:   alu_f3_c = 3'b110;
      ALU_AND:  alu_f3_c = 3'b111;
      default:  alu_ok_c = 1'b0;
    endcase
  end

  // Instruction word assembly and legality per class
  always_comb begin
    insn_c  = '0;
    legal_c = 1'b0;
    case (bus.cls_i)
      CLS_R: begin
        legal_c = alu_ok_c;
        insn_c  = {1'b0, alu_alt_c, 5'b0, rs2, rs1, alu_f3_c, rd, OP_R};
      end
      CLS_I: begin
        legal_c = alu_ok_c && (bus.alusel_i != ALU_SUB) && (alu_shift_c ? shamt_ok_c : fits12_c);
        insn_c  = alu_shift_c ? {1'b0, alu_alt_c, 5'b0, imm[4:0], rs1, alu_f3_c, rd, OP_I}
                              : {imm[11:0], rs1, alu_f3_c, rd, OP_I};
      end
      CLS_LOAD: begin
        legal_c = fits12_c && (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        insn_c  = {imm[11:0], rs1, f3, rd, OP_LOAD};
      end
      CLS_STORE: begin
        legal_c = fits12_c && (f3 <= 3'd2);
        insn_c  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      end
      CLS_BRANCH: begin
        legal_c = fits13_c && !imm[0] && (f3 != 3'd2) && (f3 != 3'd3);
        insn_c  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      end
      CLS_LUI: begin
        legal_c = (imm[11:0] == 12'h000);
        insn_c  = {imm[31:12], rd, OP_LUI};
      end
      CLS_AUIPC: begin
        legal_c = (imm[11:0] == 12'h000);
        insn_c  = {imm[31:12], rd, OP_AUIPC};
      end
      CLS_JAL: begin
        legal_c = fits21_c && !imm[0];
        insn_c  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      CLS_JALR: begin
        legal_c = fits12_c;
        insn_c  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      default: legal_c = 1'b0;
    endcase
  end

  assign ready_c        = ~out_valid_q | bus.out_ready_i;
  assign accept_c       = bus.in_valid_i & ready_c;
  assign cur_addr_c     = base_load_i ? (base_addr_i & ~AWIDTH'(3)) : cnt_q;

  // Output slot, address counter and error counter next state
  always_comb begin
    out_valid_d = out_valid_q & ~bus.out_ready_i;
    insn_d      = insn_q;
    addr_d      = addr_q;
    cnt_d       = cur_addr_c;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (accept_c) begin
      if (legal_c) begin
        out_valid_d = 1'b1;
        insn_d      = DWIDTH'(insn_c);
        addr_d      = cur_addr_c;
        cnt_d       = cur_addr_c + AWIDTH'(4);
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ECNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      insn_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      insn_q      <= insn_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready_o  = ready_c;
  assign bus.out_valid_o = out_valid_q;
  assign bus.insn_o      = insn_q;
  assign bus.addr_o      = addr_q;
  assign err_o           = err_q;
  assign err_cnt_o       = err_cnt_q;
endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: directed descriptors push expected words/error counts,
// a monitor pops and compares on every output handshake and error pulse.
module tb_insn_encoder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        base_load_i;
  logic [31:0] base_addr_i;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  insn_encoder_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  insn_encoder #(.DWIDTH(32), .AWIDTH(32), .ECNTW(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .base_load_i (base_load_i),
    .base_addr_i (base_addr_i),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          err_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_cnt = '0;
  int          err_exp = 0;
  bit          chk_flow = 1'b0;

  // Monitor: compare every accepted output word and every error pulse
  initial begin
    exp_t e;
    int   ec;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.out_valid_o && bus.out_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word insn=%08h addr=%08h", bus.insn_o, bus.addr_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.insn_o !== e.insn || bus.addr_o !== e.addr) begin
              errors++;
              $display("FAIL word got insn=%08h addr=%08h want insn=%08h addr=%08h",
                       bus.insn_o, bus.addr_o, e.insn, e.addr);
            end
          end
        end
        if (err_o) begin
          checks++;
          if (err_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_err err_cnt=%0d", err_cnt_o);
          end else begin
            ec = err_q.pop_front();
            if (int'(err_cnt_o) != ec) begin
              errors++;
              $display("FAIL err_cnt got %0d want %0d", err_cnt_o, ec);
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, got, want);
    end
  endtask

  // Offer one descriptor, wait (bounded) for acceptance and record the expectation
  task automatic send(input logic [3:0] cls, input logic [3:0] alu, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit legal, input logic [31:0] exp_insn,
                      input bit bload, input logic [31:0] baddr);
    int          n;
    logic [31:0] a;
    bus.in_valid_i = 1'b1;
    bus.cls_i      = cls;
    bus.alusel_i   = alu;
    bus.funct3_i   = f3;
    bus.rd_i       = rd;
    bus.rs1_i      = rs1;
    bus.rs2_i      = rs2;
    bus.imm_i      = imm;
    base_load_i    = bload;
    base_addr_i    = baddr;
    n = 0;
    @(negedge clk);
    if (chk_flow) begin
      checks++;
      if (!bus.in_ready_o) begin
        errors++;
        $display("FAIL flow_in_ready got 0 want 1");
      end
    end
    while (!bus.in_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=0 after %0d cycles want 1", n);
    end else begin
      a = bload ? (baddr & ~32'h3) : tb_cnt;
      if (legal) begin
        exp_q.push_back('{insn: exp_insn, addr: a});
        tb_cnt = a + 32'd4;
      end else begin
        err_exp = (err_exp == 255) ? 255 : err_exp + 1;
        err_q.push_back(err_exp);
        tb_cnt = a;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    base_load_i    = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    base_load_i     = 1'b0;
    base_addr_i     = '0;
    bus.in_valid_i  = 1'b0;
    bus.cls_i       = '0;
    bus.alusel_i    = '0;
    bus.funct3_i    = '0;
    bus.rd_i        = '0;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.imm_i       = '0;
    bus.out_ready_i = 1'b1;
    idle(2);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_insn", bus.insn_o, 32'h0);
    check("rst_addr", bus.addr_o, 32'h0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    reset_n = 1'b1;
    idle(1);

    // ADDI x1,x0,5 then R-type ADD/SUB back-to-back
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 32'h0);
    chk_flow = 1'b1;
    send(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0, 32'h0);
    send(4'd0, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 1'b0, 32'h0);
    send(4'd5, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b0, 32'h0);
    send(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF, 1'b0, 32'h0);
    send(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463, 1'b0, 32'h0);
    send(4'd3, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd12, 1'b1, 32'h0020A623, 1'b0, 32'h0);
    send(4'd2, 4'd0, 3'd2, 5'd4, 5'd1, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFFC0A203, 1'b0, 32'h0);
    send(4'd1, 4'd7, 3'd0, 5'd6, 5'd1, 5'd0, 32'd3, 1'b1, 32'h4030D313, 1'b0, 32'h0);
    send(4'd0, 4'd7, 3'd0, 5'd7, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020D3B3, 1'b0, 32'h0);
    send(4'd8, 4'd0, 3'd5, 5'd1, 5'd5, 5'd0, 32'd0, 1'b1, 32'h000280E7, 1'b0, 32'h0);
    send(4'd6, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 1'b1, 32'hFFFFF517, 1'b0, 32'h0);
    send(4'd4, 4'd0, 3'd1, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE209EE3, 1'b0, 32'h0);
    send(4'd1, 4'd5, 3'd0, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF0C113, 1'b0, 32'h0);
    chk_flow = 1'b0;
    idle(2);
    check("drain_out_valid", 32'(bus.out_valid_o), 32'd0);

    // Backpressure: one accepted, a second one stalled for 5 cycles, then release
    bus.out_ready_i = 1'b0;
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 32'h0);
    fork
      send(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0, 32'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 ||
              bus.insn_o !== 32'h00500093 || bus.addr_o !== (tb_cnt - 32'd4)) begin
            errors++;
            $display("FAIL stall_hold in_ready=%0b valid=%0b insn=%08h addr=%08h want 0 1 00500093 %08h",
                     bus.in_ready_o, bus.out_valid_o, bus.insn_o, bus.addr_o, tb_cnt - 32'd4);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    send(4'd0, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 1'b0, 32'h0);
    idle(2);

    // Illegal descriptors: dropped, counted, address untouched
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd12, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);
    check("err_cnt_3", 32'(err_cnt_o), 32'd3);
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 32'h0);
    send(4'd1, 4'd1, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd1, 4'd2, 3'd0, 5'd1, 5'd0, 5'd0, 32'd32, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd5, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000001, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd2, 4'd0, 3'd3, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd3, 4'd0, 3'd3, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd4, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, 32'h0, 1'b0, 32'h0);
    send(4'd0, 4'd12, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 288; i++)
      send(4'd12, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);
    check("err_cnt_sat", 32'(err_cnt_o), 32'hFF);

    // Base load together with acceptance, then reset while a word is pending
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b1, 32'h00001003);
    send(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0, 32'h0);
    idle(2);
    bus.out_ready_i = 1'b0;
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 32'h0);
    @(negedge clk);
    check("pend_valid", 32'(bus.out_valid_o), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt_o), 32'd0);
    exp_q.delete();
    err_q.delete();
    tb_cnt  = '0;
    err_exp = 0;
    idle(1);
    reset_n = 1'b1;
    bus.out_ready_i = 1'b1;
    idle(1);
    send(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 32'h0);
    idle(3);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);
    check("end_out_valid", 32'(bus.out_valid_o), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
